// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared constants and loader state encoding for the 4x4 Q8.8 matmul
package matmul_pkg;

    localparam int ELEM_W    = 16;
    localparam int DIM       = 4;
    localparam int FRAC_BITS = 8;
    localparam int VEC_W     = ELEM_W * DIM;
    localparam int IDX_W     = 4;
    localparam int CYC_W     = 16;

    localparam logic [IDX_W-1:0] IDX_LAST = 4'd15;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } ld_state_t;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == {CYC_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/matmul_operand_loader_if.sv
// rtl/matmul_operand_loader_if.sv - element stream, operand buses and core handshake
interface matmul_operand_loader_if;
    import matmul_pkg::*;

    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [VEC_W-1:0]  row_0;
    logic [VEC_W-1:0]  row_1;
    logic [VEC_W-1:0]  row_2;
    logic [VEC_W-1:0]  row_3;
    logic [VEC_W-1:0]  col_0;
    logic [VEC_W-1:0]  col_1;
    logic [VEC_W-1:0]  col_2;
    logic [VEC_W-1:0]  col_3;
    logic              core_reset;
    logic              core_done;
    logic              busy;
    logic              result_valid;
    logic [CYC_W-1:0]  run_cycles;

    modport slave (
        input  in_data, in_valid, abort, core_done,
        output in_ready, row_0, row_1, row_2, row_3,
               col_0, col_1, col_2, col_3,
               core_reset, busy, result_valid, run_cycles
    );

    modport master (
        output in_data, in_valid, abort, core_done,
        input  in_ready, row_0, row_1, row_2, row_3,
               col_0, col_1, col_2, col_3,
               core_reset, busy, result_valid, run_cycles
    );

endinterface

// File: rtl/matmul_operand_loader_operand_bank.sv
// rtl/matmul_operand_loader_operand_bank.sv - eight operand registers; B lands transposed
module operand_bank
    import matmul_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_wr_en,
    input  logic                      i_sel_b,
    input  logic [1:0]                i_r,
    input  logic [1:0]                i_k,
    input  logic [ELEM_W-1:0]         i_data,
    output logic [DIM-1:0][VEC_W-1:0] o_row,
    output logic [DIM-1:0][VEC_W-1:0] o_col
);

    logic [DIM-1:0][VEC_W-1:0] r_row;
    logic [DIM-1:0][VEC_W-1:0] r_col;

    // A element (r,k) goes to row r lane k; B element (r,k) goes to column k lane r.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_wr_en) begin
            if (i_sel_b)
                r_col[i_k][{i_r, 4'b0000} +: ELEM_W] <= i_data;
            else
                r_row[i_r][{i_k, 4'b0000} +: ELEM_W] <= i_data;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/matmul_operand_loader.sv
// rtl/matmul_operand_loader.sv - streams A and B into the core operand buses and sequences a run
module matmul_operand_loader
    import matmul_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    matmul_operand_loader_if.slave  bus
);

    ld_state_t                 r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_core_reset;
    logic                      r_result_valid;
    logic [CYC_W-1:0]          r_run_cycles;

    logic                      w_in_ready;
    logic                      w_xfer;
    logic [DIM-1:0][VEC_W-1:0] w_row;
    logic [DIM-1:0][VEC_W-1:0] w_col;

    assign w_in_ready = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    // An abort in the same cycle as a handshake drops the element.
    assign w_xfer     = bus.in_valid && w_in_ready && !bus.abort;

    operand_bank u_bank (
        .clock   (clock),
        .reset   (reset),
        .i_wr_en (w_xfer),
        .i_sel_b (r_state == ST_LOAD_B),
        .i_r     (r_idx[3:2]),
        .i_k     (r_idx[1:0]),
        .i_data  (bus.in_data),
        .o_row   (w_row),
        .o_col   (w_col)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_LOAD_A;
            r_idx          <= '0;
            r_core_reset   <= 1'b1;
            r_result_valid <= 1'b0;
            r_run_cycles   <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (bus.abort) begin
                r_state      <= ST_LOAD_A;
                r_idx        <= '0;
                r_core_reset <= 1'b1;
            end else begin
                case (r_state)
                    ST_LOAD_A: begin
                        if (w_xfer) begin
                            r_idx <= r_idx + 1'b1;
                            if (r_idx == IDX_LAST)
                                r_state <= ST_LOAD_B;
                        end
                    end
                    ST_LOAD_B: begin
                        if (w_xfer) begin
                            r_idx <= r_idx + 1'b1;
                            if (r_idx == IDX_LAST) begin
                                r_state      <= ST_RUN;
                                r_core_reset <= 1'b0;
                                r_run_cycles <= '0;
                            end
                        end
                    end
                    ST_RUN: begin
                        r_run_cycles <= sat_inc(r_run_cycles);
                        if (bus.core_done) begin
                            r_state        <= ST_DONE;
                            r_result_valid <= 1'b1;
                            r_core_reset   <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_LOAD_A;
                    end
                    default: begin
                        r_state <= ST_LOAD_A;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.busy         = (r_state == ST_RUN);
    assign bus.core_reset   = r_core_reset;
    assign bus.result_valid = r_result_valid;
    assign bus.run_cycles   = r_run_cycles;
    assign bus.row_0        = w_row[0];
    assign bus.row_1        = w_row[1];
    assign bus.row_2        = w_row[2];
    assign bus.row_3        = w_row[3];
    assign bus.col_0        = w_col[0];
    assign bus.col_1        = w_col[1];
    assign bus.col_2        = w_col[2];
    assign bus.col_3        = w_col[3];

endmodule

// File: doc/matmul_operand_loader.md
# matmul_operand_loader

Streaming front end for the 4x4 Q8.8 matrix-multiply core. It accepts matrix A and matrix B as a single stream of 16-bit elements over a valid/ready handshake and assembles them into the core's eight 64-bit operand buses: A by rows, B transposed into columns. It then releases the core's reset, waits for the core's `done`, and re-arms for the next operand pair. It sits between the host/DMA element stream and the multiply core's `input_row_*`/`input_col_*`/`reset`/`done` pins.

## Interface
Parameters:
- `ELEM_W`, 16: element width, Q8.8 signed.
- `DIM`, 4: matrix dimension. Fixed at 4; other values are unsupported.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_data`  in  16  operand element.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts an element this cycle.
- `abort`  in  1  synchronous; discards the current load or run.
- `row_0`..`row_3`  out  64 each  A row r. Element k is at bits [16k+15:16k].
- `col_0`..`col_3`  out  64 each  B column c. Element k (B[k][c]) is at bits [16k+15:16k].
- `core_reset`  out  1  drives the core's `reset`. High means the core is held.
- `core_done`  in  1  the core's `done`.
- `busy`  out  1  high in RUN.
- `result_valid`  out  1  one-cycle pulse when the core finishes.
- `run_cycles`  out  16  number of RUN cycles in the last run, saturating at 0xFFFF.

## Operation
- States: LOAD_A, LOAD_B, RUN, DONE.
- A transfer happens on any rising edge where `in_valid && in_ready`.
- `in_ready` is 1 in LOAD_A and LOAD_B, and 0 in RUN and DONE.
- The 4-bit index `idx` counts accepted elements within a matrix. Row is `r = idx[3:2]`, position is `k = idx[1:0]`.
- Both matrices stream in row-major order.
- LOAD_A writes `row_r[16k+:16]`.
- LOAD_B writes `col_k[16r+:16]`, which transposes B.
- When `idx` reaches 15 on a transfer, `idx` wraps to 0 and the state advances: LOAD_A goes to LOAD_B, LOAD_B goes to RUN.
- RUN: `core_reset` is 0 and `run_cycles` increments each cycle. `core_done` = 1 moves the state to DONE.
- DONE lasts one cycle: `result_valid` = 1, `core_reset` = 1, then the state returns to LOAD_A.
- Operand registers are never cleared except by `reset`. They hold their values through RUN and DONE, and during the next load until each element is overwritten.
- `abort` in any state goes to LOAD_A, sets `idx` to 0 and `core_reset` to 1, and emits no `result_valid`. Operand registers keep their contents.
- Simultaneous `abort` and `core_done`: abort wins, and no `result_valid` is emitted.
- Simultaneous `abort` and a transfer: the element is not written, and `idx` goes to 0.
- `core_done` is ignored outside RUN.
- The loader does no arithmetic on data. Element bits pass through unchanged.

## Timing
- Reset values: state LOAD_A, `idx` 0, all `row_*`/`col_*` 0, `core_reset` 1, `in_ready` 1, `busy` 0, `result_valid` 0, `run_cycles` 0.
- `reset` asserted mid-run forces the reset values immediately (asynchronously).
- `in_ready` is combinational from state only. It never depends on `in_valid`.
- Write latency: an element accepted at edge N is visible on its output bus after edge N.
- The 32nd transfer at edge N gives: `core_reset` = 0 and `busy` = 1 after edge N; `run_cycles` cleared to 0 at edge N.
- `run_cycles` counts RUN cycles up to and including the cycle where `core_done` is sampled.
- `core_done` sampled at edge M gives: state DONE with `result_valid` = 1 and `core_reset` = 1 after edge M; `in_ready` = 1 after edge M+1.
- Back-to-back streaming runs at one element per cycle, so a full load takes 32 cycles minimum.
- Any `in_valid` bubble simply stalls `idx`.
- All outputs are registered except `in_ready` and `busy`, which decode the state register.

## Structure
- Shared package `matmul_pkg`: `ELEM_W` = 16, `DIM` = 4, `FRAC_BITS` = 8, `VEC_W` = 64, and the state encoding `ld_state_t`.
- The multiply core uses the same package constants.
- One sub-module, `operand_bank`. It holds the eight 64-bit registers and the write decode. Inputs: `wr_en`, `sel_b`, `r`, `k`, `data`.
- The FSM, `idx` counter and `run_cycles` counter live in `matmul_operand_loader`.

## Test plan
- **Reset:** assert `reset` with no clock edge. All outputs take their reset values at once, and `core_reset` = 1.
- **Full load, no gaps:** stream A = 0x0000, 0x0100 … (the row-major values 0..3, 4..7, 8,9,1,1, 2,3,4,5 in Q8.8), then B row-major = 0,1,2,3 / 4,5,6,7 / 8,9,1,1 / 1,1,4,5 in Q8.8. Required buses:
  - `row_0` = {0300,0200,0100,0000}
  - `col_0` = {0100,0800,0400,0000}
  - `col_3` = {0500,0100,0700,0300}
  - `core_reset` falls the cycle after the 32nd element.
- **Completion:** drive `core_done` 7 cycles into RUN. Required: one `result_valid` pulse, `run_cycles` = 7, `core_reset` = 1, `in_ready` = 1 the following cycle.
- **Backpressure/bubbles:** toggle `in_valid` randomly. Only accepted elements advance `idx`. Final buses match the gap-free result.
- **Abort mid-load:** abort after 20 elements. Required: state LOAD_A, `idx` 0, no RUN entered. A fresh 32-element load then completes correctly.
- **Abort vs done collision:** assert `abort` and `core_done` in the same RUN cycle. Required: no `result_valid`, state LOAD_A, `core_reset` = 1.
